// File: rtl/sp_ram_pkg.sv
// Shared constants, types and helpers for the byte-lane SP RAM.
// Write/read mode codes, clear FSM state type, lane count helper.
package sp_ram_pkg;

  localparam int WM_NORMAL            = 0;
  localparam int WM_WRITE_THROUGH     = 1;
  localparam int WM_READ_BEFORE_WRITE = 2;

  localparam int RM_BYPASS   = 0;
  localparam int RM_PIPELINE = 1;

  typedef enum logic {
    CLR_CLEAR,
    CLR_READY
  } clr_state_t;

  function automatic int num_lanes(input int dw, input int lw);
    return (dw + lw - 1) / lw;
  endfunction

endpackage

// File: rtl/sp_ram_if.sv
// Access bus of the byte-lane SP RAM.
// master drives ce/oce/wre/ad/din/byte_en; slave returns dout/init_busy/parity_err.
interface sp_ram_if
  import sp_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 21,
  parameter int LANE_W = 8
);

  localparam int NUM_LANES = num_lanes(DATA_W, LANE_W);

  logic                 ce;
  logic                 oce;
  logic                 wre;
  logic [ADDR_W-1:0]    ad;
  logic [DATA_W-1:0]    din;
  logic [NUM_LANES-1:0] byte_en;
  logic [DATA_W-1:0]    dout;
  logic                 init_busy;
  logic                 parity_err;

  modport master (
    output ce, oce, wre, ad, din, byte_en,
    input  dout, init_busy, parity_err
  );

  modport slave (
    input  ce, oce, wre, ad, din, byte_en,
    output dout, init_busy, parity_err
  );

endinterface

// File: rtl/sp_ram_be_param_clear_fsm.sv
// Post-reset clear sweep: walks clr_ptr_o over every word, then goes READY.
// Ports: clk_i, reset_i (sync, high) -> clr_ptr_o, init_busy_o.
module sp_ram_be_param_clear_fsm
  import sp_ram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic [ADDR_W-1:0] clr_ptr_o,
  output logic              init_busy_o
);

  clr_state_t        state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= CLR_CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        CLR_CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          // last word written this cycle
          if (ptr_q == '1) begin
            state_q <= CLR_READY;
            busy_q  <= 1'b0;
          end
        end
        CLR_READY: begin
          state_q <= CLR_READY;
        end
      endcase
    end
  end

  assign clr_ptr_o   = ptr_q;
  assign init_busy_o = busy_q;

endmodule

// File: rtl/sp_ram_be_param.sv
// Single-port sync RAM, per-lane write enables, write/read modes, clear sweep.
// Ports: clk, reset (sync, high), bus (sp_ram_if.slave). Option: SP_RAM_PARITY_EN.
module sp_ram_be_param
  import sp_ram_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 21,
  parameter int LANE_W     = 8,
  parameter int READ_MODE  = 0,
  parameter int WRITE_MODE = 1
) (
  input logic     clk,
  input logic     reset,
  sp_ram_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NL    = num_lanes(DATA_W, LANE_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] clr_ptr;
  logic              busy;
  logic              acc;
  logic              wr;
  logic [DATA_W-1:0] old_w;
  logic [DATA_W-1:0] new_w;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] rd_q;
  logic              rd_err_q;
  logic              rd_chk;
  logic              wt_chk;

  function automatic logic [DATA_W-1:0] lane_mask(
    input logic [NL-1:0] be
  );
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < DATA_W; b++) m[b] = be[b / LANE_W];
    return m;
  endfunction

  sp_ram_be_param_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk_i       (clk),
    .reset_i     (reset),
    .clr_ptr_o   (clr_ptr),
    .init_busy_o (busy)
  );

  assign acc = bus.ce && !busy && !reset;
  assign wr  = acc && bus.wre;

  always_comb begin
    old_w = mem_q[bus.ad];
    mask  = lane_mask(bus.byte_en);
    new_w = (old_w & ~mask) | (bus.din & mask);
  end

  always_ff @(posedge clk) begin
    if (busy) mem_q[clr_ptr] <= '0;
    else if (wr) mem_q[bus.ad] <= new_w;
  end

`ifdef SP_RAM_PARITY_EN
  logic [NL-1:0] par_q [DEPTH];
  logic [NL-1:0] old_par;
  logic [NL-1:0] new_par;

  function automatic logic [NL-1:0] lane_par(
    input logic [DATA_W-1:0] d
  );
    logic [NL-1:0] p;
    p = '0;
    for (int b = 0; b < DATA_W; b++)
      p[b / LANE_W] = p[b / LANE_W] ^ d[b];
    return p;
  endfunction

  always_comb begin
    old_par = par_q[bus.ad];
    new_par = (old_par & ~bus.byte_en)
            | (lane_par(bus.din) & bus.byte_en);
  end

  assign rd_chk = |(lane_par(old_w) ^ old_par);
  assign wt_chk = |(lane_par(new_w) ^ new_par);

  always_ff @(posedge clk) begin
    if (busy) par_q[clr_ptr] <= '0;
    else if (wr) par_q[bus.ad] <= new_par;
  end
`else
  assign rd_chk = 1'b0;
  assign wt_chk = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q     <= '0;
      rd_err_q <= 1'b0;
    end else if (acc) begin
      if (!bus.wre) begin
        rd_q     <= old_w;
        rd_err_q <= rd_chk;
      end else if (WRITE_MODE == WM_WRITE_THROUGH) begin
        rd_q     <= new_w;
        rd_err_q <= wt_chk;
      end else if (WRITE_MODE == WM_READ_BEFORE_WRITE) begin
        rd_q     <= old_w;
        rd_err_q <= rd_chk;
      end
    end
  end

  if (READ_MODE == RM_PIPELINE) begin : g_pipe
    logic [DATA_W-1:0] dout_q;
    logic              err_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        dout_q <= '0;
        err_q  <= 1'b0;
      end else if (bus.oce) begin
        dout_q <= rd_q;
        err_q  <= rd_err_q;
      end
    end
    assign bus.dout       = dout_q;
    assign bus.parity_err = err_q;
  end else begin : g_byp
    assign bus.dout       = rd_q;
    assign bus.parity_err = rd_err_q;
  end

  assign bus.init_busy = busy;

endmodule
